mux4_rr_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 4:1 datapath mux among four requesters.
- Grants one requester at a time and drives the mux select.
- Passes the selected requester's data and valid/ready handshake to a single downstream consumer.
- Holds a grant for a multi-beat burst until the requester's last beat or a beat-limit cap, then rotates priority.

---
 rtl/mux4_rr_arbiter_if.sv | 29 ++
 rtl/mux4_rr_arbiter.sv | 93 +++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle for the 4-way round-robin mux arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mux4_rr_arbiter_if #(
    parameter int SIZE = 1
);
    logic [3:0]      req_valid;
    logic [3:0]      req_last;
    logic [3:0]      req_ready;
    logic [SIZE-1:0] x0;
    logic [SIZE-1:0] x1;
    logic [SIZE-1:0] x2;
    logic [SIZE-1:0] x3;
    logic [SIZE-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      InsSel;
    logic [3:0]      grant;
    logic            busy;

    modport slave (
        input  req_valid, req_last, x0, x1, x2, x3, out_ready,
        output req_ready, out_data, out_valid, InsSel, grant, busy
    );

    modport master (
        output req_valid, req_last, x0, x1, x2, x3, out_ready,
        input  req_ready, out_data, out_valid, InsSel, grant, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters,
// holding each grant for a burst (last beat or MAX_BEATS cap).
module mux4_rr_arbiter #(
    parameter int SIZE      = 1,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mux4_rr_arbiter_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]      state;
    logic [1:0]      last_grant;
    logic [1:0]      sel_q;
    logic [3:0]      grant_q;
    logic [7:0]      beat_cnt;
    logic [1:0]      scan_idx;
    logic [1:0]      win_idx;
    logic            win_found;
    logic            beat_done;
    logic            rel;
    logic [SIZE-1:0] data_mux;

    // Scan starts one past the previous winner and wraps; offset 4 lands on last_grant itself.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            scan_idx = last_grant + 2'(k);
            if (!win_found && bus.req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.req_ready = '0;
        if (state == BUSY) begin
            bus.out_valid        = bus.req_valid[sel_q];
            bus.req_ready[sel_q] = bus.out_ready;
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    data_mux = bus.x0;
            2'd1:    data_mux = bus.x1;
            2'd2:    data_mux = bus.x2;
            default: data_mux = bus.x3;
        endcase
    end

    assign bus.out_data = data_mux;
    assign beat_done    = (state == BUSY) && bus.out_valid && bus.out_ready;
    assign rel          = beat_done &&
                          (bus.req_last[sel_q] || (beat_cnt == 8'(MAX_BEATS - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            sel_q      <= '0;
            grant_q    <= '0;
            beat_cnt   <= '0;
        end else if (state == IDLE) begin
            if (win_found) begin
                state    <= BUSY;
                sel_q    <= win_idx;
                grant_q  <= 4'b0001 << win_idx;
                beat_cnt <= '0;
            end
        end else begin
            // A stalled granted requester keeps the grant; only a completed beat can release.
            if (rel) begin
                state      <= IDLE;
                last_grant <= sel_q;
                grant_q    <= '0;
                beat_cnt   <= '0;
            end else if (beat_done) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    assign bus.InsSel = sel_q;
    assign bus.grant  = grant_q;
    assign bus.busy   = (state == BUSY);
endmodule
